// File: rtl/multichannel_oversampler.sv
// Purpose: per-channel oversampling accumulator, ratio 2^osr_sel (clamped), full-scale normalised output.
// Latency: block-completing sample in cycle t -> out_valid high in cycle t+2 when the output is idle.
// Backpressure: valid/ready output; one pending result per channel, a newer block is dropped and flagged in overrun.
module multichannel_oversampler #(
    parameter int NCH      = 4,
    parameter int IN_W     = 12,
    parameter int LOG2_OSR = 8,
    parameter int OUT_W    = 16,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       osr_sel,
    input  logic             in_valid,
    input  logic [CHW-1:0]   in_channel,
    input  logic [IN_W-1:0]  in_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHW-1:0]   out_channel,
    output logic [OUT_W-1:0] out_data,
    output logic [NCH-1:0]   overrun,
    input  logic             clr_overrun
);

    localparam int AW = IN_W + LOG2_OSR;
    localparam int CW = LOG2_OSR + 1;
    localparam logic [3:0] MAX_OSR = 4'(LOG2_OSR);

    // ratio control
    logic [3:0]       osr_q;
    logic [3:0]       osr_clamp;
    logic             osr_chg;

    // per-channel state
    logic [AW-1:0]    acc  [NCH];
    logic [CW-1:0]    cnt  [NCH];
    logic [NCH-1:0]   pend;
    logic [OUT_W-1:0] pres [NCH];

    // accumulate datapath (only one channel can be hit per cycle)
    logic             hit;
    logic [NCH-1:0]   sel;
    logic [AW-1:0]    acc_sel;
    logic [CW-1:0]    cnt_sel;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    shifted;
    logic [CW-1:0]    blk_len;
    logic             blk_done;
    logic [OUT_W-1:0] blk_res;

    // per-channel events
    logic [NCH-1:0]   done_v;
    logic [NCH-1:0]   take_v;
    logic [NCH-1:0]   drop_v;

    // output arbitration
    logic [CHW-1:0]   last_grant;
    logic             win_vld;
    logic [CHW-1:0]   win;
    logic             load;

    // Clamp the requested ratio and detect a change against the active one.
    always_comb begin
        osr_clamp = (osr_sel > MAX_OSR) ? MAX_OSR : osr_sel;
        osr_chg   = (osr_clamp != osr_q);
    end

    // Select the addressed channel, add the sample and normalise a finished block.
    always_comb begin
        hit     = in_valid && !osr_chg && (32'(in_channel) < NCH);
        sel     = '0;
        acc_sel = '0;
        cnt_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (hit && (in_channel == CHW'(c))) begin
                sel[c]  = 1'b1;
                acc_sel = acc[c];
                cnt_sel = cnt[c];
            end
        end
        sum      = acc_sel + AW'(in_sample);
        blk_len  = CW'(1) << osr_q;
        blk_done = (cnt_sel == (blk_len - CW'(1)));
        // Shifting up by the unused ratio bits keeps full scale at the top of AW.
        shifted  = sum << (MAX_OSR - osr_q);
        blk_res  = OUT_W'(shifted >> (AW - OUT_W));
    end

    // Round-robin pick among pending channels, starting after the last grant.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant) + k) % NCH;
            if (!win_vld && pend[idx]) begin
                win_vld = 1'b1;
                win     = CHW'(idx);
            end
        end
        load = win_vld && (!out_valid || out_ready);
    end

    // Per-channel completion, hand-off to the output and drop detection.
    always_comb begin
        done_v = '0;
        take_v = '0;
        drop_v = '0;
        for (int c = 0; c < NCH; c++) begin
            done_v[c] = sel[c] && blk_done;
            take_v[c] = load && (win == CHW'(c));
            // A slot being handed off this cycle is free for the new result.
            drop_v[c] = done_v[c] && pend[c] && !take_v[c];
        end
    end

    // Active ratio register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osr_q <= '0;
        end else begin
            osr_q <= osr_clamp;
        end
    end

    // Accumulators and sample counters; a ratio change restarts every block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (osr_chg) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (sel[c]) begin
                    if (blk_done) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum;
                        cnt[c] <= cnt[c] + CW'(1);
                    end
                end
            end
        end
    end

    // Pending results and sticky overrun flags; a new overrun beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= '0;
            overrun <= '0;
            for (int c = 0; c < NCH; c++) begin
                pres[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                pend[c] <= (pend[c] && !take_v[c]) || done_v[c];
                if (done_v[c] && !drop_v[c]) begin
                    pres[c] <= blk_res;
                end
                if (drop_v[c]) begin
                    overrun[c] <= 1'b1;
                end else if (clr_overrun) begin
                    overrun[c] <= 1'b0;
                end
            end
        end
    end

    // Output register: reload on free slot, hold while stalled, empty when drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            last_grant  <= CHW'(NCH - 1);
        end else if (load) begin
            out_valid   <= 1'b1;
            out_channel <= win;
            out_data    <= pres[win];
            last_grant  <= win;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multichannel_oversampler.sv
// Purpose: directed scenarios plus randomized traffic against a behavioural model of the oversampler.
// Latency: model advances once per rising edge; DUT outputs sampled 1 time unit after that edge.
// Backpressure: out_ready driven both fixed and randomly to exercise stalls, hand-offs and overruns.
module tb_multichannel_oversampler;

    localparam int NCH   = 2;
    localparam int IN_W  = 12;
    localparam int L     = 8;
    localparam int OUT_W = 16;
    localparam int AW    = IN_W + L;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       osr_sel;
    logic             in_valid;
    logic [0:0]       in_channel;
    logic [IN_W-1:0]  in_sample;
    logic             out_valid;
    logic             out_ready;
    logic [0:0]       out_channel;
    logic [OUT_W-1:0] out_data;
    logic [NCH-1:0]   overrun;
    logic             clr_overrun;

    always #5 clk = ~clk;

    multichannel_oversampler #(
        .NCH(NCH), .IN_W(IN_W), .LOG2_OSR(L), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .osr_sel(osr_sel),
        .in_valid(in_valid), .in_channel(in_channel), .in_sample(in_sample),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_data(out_data),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int           m_acc  [NCH];
    int           m_cnt  [NCH];
    int           m_pres [NCH];
    bit           m_pend [NCH];
    int           m_osr;
    bit [NCH-1:0] m_ov;
    bit           m_ovld;
    int           m_och;
    int           m_odat;
    int           m_last;

    // DUT words seen accepted, and the cycle of acceptance
    logic [16:0] wq[$];
    int          wcyc[$];
    int          cyc = 0;
    logic        s_vld = 1'b0;
    logic [0:0]  s_ch  = '0;
    logic [15:0] s_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        if (i < wq.size()) return 32'(wq[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_cnt[c] = 0; m_pres[c] = 0; m_pend[c] = 0;
        end
        m_osr = 0; m_ov = '0; m_ovld = 0; m_och = 0; m_odat = 0; m_last = NCH - 1;
    endtask

    // One clock of the block's rules, evaluated from the pre-edge state and inputs.
    task automatic model_step();
        int clamp;
        bit free;
        int win;
        int c;
        int sum;
        int odat_new;
        bit npend [NCH];
        bit [NCH-1:0] nov;
        clamp = (int'(osr_sel) > L) ? L : int'(osr_sel);
        free  = !m_ovld || out_ready;
        win   = -1;
        if (free) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (win < 0 && m_pend[c]) win = c;
            end
        end
        for (int i = 0; i < NCH; i++) npend[i] = m_pend[i];
        if (win >= 0) npend[win] = 0;
        odat_new = (win >= 0) ? m_pres[win] : 0;
        nov = clr_overrun ? '0 : m_ov;
        if (clamp != m_osr) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_cnt[i] = 0;
            end
        end else if (in_valid && int'(in_channel) < NCH) begin
            c   = int'(in_channel);
            sum = m_acc[c] + int'(in_sample);
            if (m_cnt[c] + 1 == (1 << m_osr)) begin
                m_acc[c] = 0;
                m_cnt[c] = 0;
                if (m_pend[c] && win != c) begin
                    nov[c] = 1'b1;
                end else begin
                    m_pres[c] = ((sum << (L - m_osr)) >> (AW - OUT_W)) & 'hFFFF;
                    npend[c]  = 1'b1;
                end
            end else begin
                m_acc[c] = sum;
                m_cnt[c] = m_cnt[c] + 1;
            end
        end
        if (win >= 0) begin
            m_ovld = 1; m_och = win; m_odat = odat_new; m_last = win;
        end else if (m_ovld && out_ready) begin
            m_ovld = 0;
        end
        m_osr = clamp;
        for (int i = 0; i < NCH; i++) m_pend[i] = npend[i];
        m_ov = nov;
    endtask

    // Advance one clock, update the model and compare all outputs.
    task automatic step();
        if (s_vld && out_ready) begin
            wq.push_back({s_ch, s_dat});
            wcyc.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        s_vld = out_valid;
        s_ch  = out_channel;
        s_dat = out_data;
        chk("out_valid", 32'(out_valid), 32'(m_ovld));
        if (m_ovld) begin
            chk("out_channel", 32'(out_channel), 32'(m_och));
            chk("out_data", 32'(out_data), 32'(m_odat));
        end
        chk("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic drive(input bit v, input int ch, input int smp);
        in_valid   = v;
        in_channel = 1'(ch);
        in_sample  = IN_W'(smp);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_ch"},  32'(out_channel), 32'd0);
        chk({tag, "_dat"}, 32'(out_data), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; osr_sel = 4'd0; in_valid = 1'b0; in_channel = '0;
        in_sample = '0; out_ready = 1'b1; clr_overrun = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 16x of full-scale on ch0
        osr_sel = 4'd4; idle(1); wq.delete(); wcyc.delete();
        for (int i = 0; i < 16; i++) drive(1, 0, 'hFFF);
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        drive(0, 0, 0);
        chk("t1_vld", 32'(out_valid), 32'd1);
        chk("t1_dat", 32'(out_data), 32'hFFF0);
        chk("t1_ch",  32'(out_channel), 32'd0);
        idle(2);
        chk("t1_count", 32'(wq.size()), 32'd1);

        // 256x on both channels, interleaved
        osr_sel = 4'd8; idle(1); wq.delete(); wcyc.delete();
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 'h800);
            drive(1, 0, 'h400);
        end
        idle(3);
        chk("t2_count", 32'(wq.size()), 32'd2);
        chk("t2_w0", wq_at(0), 32'h18000);
        chk("t2_w1", wq_at(1), 32'h04000);
        chk("t2_ovr", 32'(overrun), 32'd0);

        // pass-through
        osr_sel = 4'd0; idle(1); wq.delete(); wcyc.delete();
        drive(1, 0, 'h123);
        drive(1, 0, 'hABC);
        idle(3);
        chk("t3_count", 32'(wq.size()), 32'd2);
        chk("t3_w0", wq_at(0), 32'h01230);
        chk("t3_w1", wq_at(1), 32'h0ABC0);
        if (wcyc.size() == 2) chk("t3_gap", 32'(wcyc[1] - wcyc[0]), 32'd1);

        // stalled output, overrun and clear
        out_ready = 1'b0; wq.delete(); wcyc.delete();
        drive(1, 0, 'h001);
        drive(1, 0, 'h002);
        drive(1, 0, 'h003);
        chk("t4_hold", 32'(out_data), 32'h0010);
        chk("t4_ovr", 32'(overrun), 32'd1);
        clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
        chk("t4_clr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        idle(3);
        chk("t4_count", 32'(wq.size()), 32'd2);
        chk("t4_w0", wq_at(0), 32'h00010);
        chk("t4_w1", wq_at(1), 32'h00020);

        // two channels completing on adjacent cycles, round-robin with no bubble
        osr_sel = 4'd2; idle(1); wq.delete(); wcyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, int'($urandom_range(0, 4095)));
            drive(1, 1, int'($urandom_range(0, 4095)));
        end
        idle(3);
        chk("t5_count", 32'(wq.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("t5_grant", 32'(wq_at(k) >> 16), 32'(k % 2));
        if (wcyc.size() == 4) begin
            chk("t5_gap01", 32'(wcyc[1] - wcyc[0]), 32'd1);
            chk("t5_gap23", 32'(wcyc[3] - wcyc[2]), 32'd1);
        end

        // ratio change mid-block discards the partial block
        osr_sel = 4'd4; idle(1); wq.delete(); wcyc.delete();
        for (int i = 0; i < 10; i++) drive(1, 0, int'($urandom_range(0, 4095)));
        osr_sel = 4'd3;
        drive(1, 0, 'hFFF);
        for (int i = 0; i < 8; i++) drive(1, 0, 'h100);
        idle(3);
        chk("t6_count", 32'(wq.size()), 32'd1);
        chk("t6_w0", wq_at(0), 32'h01000);

        // reset mid-block with a stalled word and a set overrun flag
        out_ready = 1'b0; osr_sel = 4'd0; idle(1);
        drive(1, 0, 'h111); drive(1, 0, 'h222); drive(1, 0, 'h333);
        osr_sel = 4'd4; idle(1);
        for (int i = 0; i < 10; i++) drive(1, 1, 'hFFF);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        s_vld = 1'b0;
        out_ready = 1'b1; wq.delete(); wcyc.delete();
        idle(20);
        chk("t6_rst_count", 32'(wq.size()), 32'd0);
        check_reset_outputs("t6_post");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 4))
                    0: osr_sel = 4'd0;
                    1: osr_sel = 4'd1;
                    2: osr_sel = 4'd2;
                    3: osr_sel = 4'd3;
                    default: osr_sel = 4'd12;
                endcase
            end
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4095)));
        end
        clr_overrun = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
